// File: rtl/ifmap_buf_pkg.sv
// Shared types and helpers for the ping-pong ifmap buffer.
// The length typedef matches the default 128-word bank.
package ifmap_buf_pkg;

  localparam int DEF_DEPTH  = 128;
  localparam int DEF_ADDR_W = $clog2(DEF_DEPTH);

  typedef logic                  bank_idx_t;
  typedef logic [DEF_ADDR_W:0]   len_t;

  // A frame length of zero, or one larger than the bank, means "whole bank".
  function automatic logic [31:0] clamp_len(input logic [31:0] len,
                                            input logic [31:0] depth);
    if (len == 32'd0 || len > depth) begin
      return depth;
    end
    return len;
  endfunction

endpackage

// File: rtl/ifmap_bank.sv
// Single-port SRAM bank with a registered read port.
// Only the output register is reset; the array contents survive reset.
module ifmap_bank #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 128,
  parameter int ADDR_W     = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  we,
  input  logic [ADDR_W-1:0]     addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_reg;

  always_ff @(posedge clk) begin
    if (en && we) begin
      mem[addr] <= wdata;
    end
  end

  // The output register keeps its value between reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_reg <= '0;
    end else if (en && !we) begin
      rdata_reg <= mem[addr];
    end
  end

  assign rdata = rdata_reg;

endmodule

// File: rtl/ifmap_pingpong_buf.sv
// Double-buffered ifmap store: a producer fills one bank while the PE array reads the other.
// Optional IFMAP_BUF_ZERO_PAD_EN returns zeros for reads beyond the frame length.
module ifmap_pingpong_buf
  import ifmap_buf_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 128,
  parameter int ADDR_W     = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_W:0]       frame_len_i,
  input  logic                  wr_valid_i,
  output logic                  wr_ready_o,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  output logic                  rd_bank_valid_o,
  output logic [ADDR_W:0]       rd_len_o,
  input  logic                  rd_req_i,
  input  logic [ADDR_W-1:0]     rd_addr_i,
  output logic                  rd_valid_o,
  output logic [DATA_WIDTH-1:0] rd_data_o,
  input  logic                  rd_done_i,
  output logic [1:0]            full_cnt_o
);

  localparam int LEN_W = ADDR_W + 1;

  logic [1:0]            full_reg;
  logic [LEN_W-1:0]      len_reg [2];
  bank_idx_t             fill_bank_reg;
  bank_idx_t             rd_bank_reg;
  bank_idx_t             rd_sel_reg;
  logic [ADDR_W-1:0]     wr_ptr_reg;
  logic                  rd_valid_reg;
  logic                  pad_reg;

  logic                  wr_fire;
  logic                  wr_last;
  logic                  rd_fire;
  logic                  rd_release;
  logic                  rd_pad;
  logic [LEN_W-1:0]      frame_len_clamped;
  logic [LEN_W-1:0]      eff_len;
  logic [DATA_WIDTH-1:0] bank_q [2];

  assign wr_ready_o      = !full_reg[fill_bank_reg];
  assign rd_bank_valid_o = full_reg[rd_bank_reg];
  assign rd_len_o        = rd_bank_valid_o ? len_reg[rd_bank_reg] : '0;
  assign full_cnt_o      = {1'b0, full_reg[0]} + {1'b0, full_reg[1]};

  assign wr_fire    = wr_valid_i && wr_ready_o;
  assign rd_fire    = rd_req_i && rd_bank_valid_o;
  assign rd_release = rd_done_i && rd_bank_valid_o;

  // The first word of a frame uses the live length; later words use the latched one.
  assign frame_len_clamped = LEN_W'(clamp_len(32'(frame_len_i), 32'(DEPTH)));
  assign eff_len = (wr_ptr_reg == '0) ? frame_len_clamped : len_reg[fill_bank_reg];
  assign wr_last = ({1'b0, wr_ptr_reg} == (eff_len - LEN_W'(1)));

`ifdef IFMAP_BUF_ZERO_PAD_EN
  assign rd_pad = ({1'b0, rd_addr_i} >= rd_len_o);
`else
  assign rd_pad = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_reg      <= '0;
      len_reg[0]    <= '0;
      len_reg[1]    <= '0;
      fill_bank_reg <= 1'b0;
      rd_bank_reg   <= 1'b0;
      rd_sel_reg    <= 1'b0;
      wr_ptr_reg    <= '0;
      rd_valid_reg  <= 1'b0;
      pad_reg       <= 1'b0;
    end else begin
      rd_valid_reg <= rd_fire;
      if (rd_fire) begin
        rd_sel_reg <= rd_bank_reg;
        pad_reg    <= rd_pad;
      end

      if (wr_fire) begin
        if (wr_ptr_reg == '0) begin
          len_reg[fill_bank_reg] <= frame_len_clamped;
        end
        if (wr_last) begin
          full_reg[fill_bank_reg] <= 1'b1;
          wr_ptr_reg              <= '0;
          fill_bank_reg           <= ~fill_bank_reg;
        end else begin
          wr_ptr_reg <= wr_ptr_reg + 1'b1;
        end
      end

      // Fill requires an empty bank and release a full one, so these never collide.
      if (rd_release) begin
        full_reg[rd_bank_reg] <= 1'b0;
        rd_bank_reg           <= ~rd_bank_reg;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_bank
      logic bank_wr;
      logic bank_rd;

      assign bank_wr = wr_fire && (fill_bank_reg == bank_idx_t'(gi));
      assign bank_rd = rd_fire && !rd_pad && (rd_bank_reg == bank_idx_t'(gi));

      ifmap_bank #(
        .DATA_WIDTH(DATA_WIDTH),
        .DEPTH     (DEPTH),
        .ADDR_W    (ADDR_W)
      ) u_bank (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (bank_wr || bank_rd),
        .we   (bank_wr),
        .addr (bank_wr ? wr_ptr_reg : rd_addr_i),
        .wdata(wr_data_i),
        .rdata(bank_q[gi])
      );
    end
  endgenerate

  assign rd_valid_o = rd_valid_reg;
  assign rd_data_o  = pad_reg ? '0 : bank_q[rd_sel_reg];

endmodule

// File: tb/tb_ifmap_pingpong_buf.sv
// Self-checking bench for ifmap_pingpong_buf: read data is scoreboarded by a monitor,
// control outputs are checked inline by each scenario task.
module tb_ifmap_pingpong_buf;

  localparam int DW = 8;
  localparam int DEPTH = 128;
  localparam int AW = 7;
  localparam int LW = AW + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [LW-1:0] frame_len_i = '0;
  logic          wr_valid_i = 1'b0;
  logic          wr_ready_o;
  logic [DW-1:0] wr_data_i = '0;
  logic          rd_bank_valid_o;
  logic [LW-1:0] rd_len_o;
  logic          rd_req_i = 1'b0;
  logic [AW-1:0] rd_addr_i = '0;
  logic          rd_valid_o;
  logic [DW-1:0] rd_data_o;
  logic          rd_done_i = 1'b0;
  logic [1:0]    full_cnt_o;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] sb [$];

  ifmap_pingpong_buf #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .frame_len_i    (frame_len_i),
    .wr_valid_i     (wr_valid_i),
    .wr_ready_o     (wr_ready_o),
    .wr_data_i      (wr_data_i),
    .rd_bank_valid_o(rd_bank_valid_o),
    .rd_len_o       (rd_len_o),
    .rd_req_i       (rd_req_i),
    .rd_addr_i      (rd_addr_i),
    .rd_valid_o     (rd_valid_o),
    .rd_data_o      (rd_data_o),
    .rd_done_i      (rd_done_i),
    .full_cnt_o     (full_cnt_o)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  // Monitor: every rd_valid_o must match the oldest expected read.
  always begin
    @(posedge clk);
    #1;
    if (rd_valid_o === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL rd_unexpected: got rd_valid_o=1 data=%02h, required no read response", rd_data_o);
      end else begin
        logic [DW-1:0] exp;
        exp = sb.pop_front();
        if (rd_data_o !== exp) begin
          errors++;
          $display("FAIL rd_data: got %02h, required %02h", rd_data_o, exp);
        end else begin
          $display("read ok: data=%02h", rd_data_o);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] pat(input int pid, input int i);
    case (pid)
      0: return DW'(i + 1);
      1: return DW'(i) ^ 8'h5A;
      2: return ~DW'(i);
      3: return DW'(8'h10 + i);
      4: return DW'(8'hC0 + i);
      5: return DW'(8'hA0 + i);
      6: return DW'(8'hB0 + i);
      default: return DW'(i * 3 + 7);
    endcase
  endfunction

  task automatic apply_reset();
    wr_valid_i = 1'b0;
    rd_req_i   = 1'b0;
    rd_done_i  = 1'b0;
    rst_n      = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic write_n(input logic [LW-1:0] flen, input int pid, input int start, input int n);
    for (int i = start; i < start + n; i++) begin
      int guard;
      guard = 0;
      frame_len_i = flen;
      wr_data_i   = pat(pid, i);
      wr_valid_i  = 1'b1;
      while (wr_ready_o !== 1'b1 && guard < 300) begin
        tick();
        guard++;
      end
      if (guard >= 300) begin
        checks++;
        errors++;
        $display("FAIL wr_stall: got wr_ready_o=%b for 300 cycles, required 1", wr_ready_o);
      end
      tick();
    end
    wr_valid_i = 1'b0;
    $display("write: len=%0d pattern=%0d elements %0d..%0d", flen, pid, start, start + n - 1);
  endtask

  task automatic read_one(input logic [AW-1:0] addr, input logic [DW-1:0] exp);
    rd_req_i  = 1'b1;
    rd_addr_i = addr;
    sb.push_back(exp);
    tick();
    rd_req_i = 1'b0;
  endtask

  task automatic release_bank();
    rd_done_i = 1'b1;
    tick();
    rd_done_i = 1'b0;
    $display("release: full_cnt=%0d", full_cnt_o);
  endtask

  task automatic test_reset();
    apply_reset();
    checks += 6;
    if (wr_ready_o !== 1'b1) begin errors++; $display("FAIL reset_wr_ready: got %b, required 1", wr_ready_o); end
    if (rd_bank_valid_o !== 1'b0) begin errors++; $display("FAIL reset_bank_valid: got %b, required 0", rd_bank_valid_o); end
    if (rd_len_o !== '0) begin errors++; $display("FAIL reset_rd_len: got %0d, required 0", rd_len_o); end
    if (rd_valid_o !== 1'b0) begin errors++; $display("FAIL reset_rd_valid: got %b, required 0", rd_valid_o); end
    if (rd_data_o !== '0) begin errors++; $display("FAIL reset_rd_data: got %02h, required 00", rd_data_o); end
    if (full_cnt_o !== 2'd0) begin errors++; $display("FAIL reset_full_cnt: got %0d, required 0", full_cnt_o); end
    $display("reset: outputs checked");
  endtask

  task automatic test_basic_fill_read();
    apply_reset();
    write_n(8'd4, 0, 0, 3);
    checks++;
    if (rd_bank_valid_o !== 1'b0) begin errors++; $display("FAIL basic_partial_valid: got %b, required 0", rd_bank_valid_o); end
    write_n(8'd4, 0, 3, 1);
    checks += 3;
    if (rd_bank_valid_o !== 1'b1) begin errors++; $display("FAIL basic_bank_valid: got %b, required 1", rd_bank_valid_o); end
    if (rd_len_o !== 8'd4) begin errors++; $display("FAIL basic_rd_len: got %0d, required 4", rd_len_o); end
    if (full_cnt_o !== 2'd1) begin errors++; $display("FAIL basic_full_cnt: got %0d, required 1", full_cnt_o); end
    for (int a = 0; a < 4; a++) read_one(AW'(a), pat(0, a));
    tick();
    release_bank();
    checks += 2;
    if (rd_bank_valid_o !== 1'b0) begin errors++; $display("FAIL basic_release_valid: got %b, required 0", rd_bank_valid_o); end
    if (full_cnt_o !== 2'd0) begin errors++; $display("FAIL basic_release_cnt: got %0d, required 0", full_cnt_o); end
  endtask

  task automatic test_both_full();
    apply_reset();
    write_n(8'd128, 1, 0, 128);
    write_n(8'd128, 2, 0, 128);
    checks += 2;
    if (wr_ready_o !== 1'b0) begin errors++; $display("FAIL full_wr_ready: got %b, required 0", wr_ready_o); end
    if (full_cnt_o !== 2'd2) begin errors++; $display("FAIL full_cnt_two: got %0d, required 2", full_cnt_o); end
    wr_valid_i = 1'b1;
    wr_data_i  = 8'hEE;
    tick();
    wr_valid_i = 1'b0;
    checks++;
    if (full_cnt_o !== 2'd2) begin errors++; $display("FAIL full_drop_cnt: got %0d, required 2", full_cnt_o); end
    read_one(7'd0, pat(1, 0));
    read_one(7'd127, pat(1, 127));
    tick();
    release_bank();
    checks += 3;
    if (wr_ready_o !== 1'b1) begin errors++; $display("FAIL full_release_ready: got %b, required 1", wr_ready_o); end
    if (full_cnt_o !== 2'd1) begin errors++; $display("FAIL full_release_cnt: got %0d, required 1", full_cnt_o); end
    if (rd_len_o !== 8'd128) begin errors++; $display("FAIL full_bank1_len: got %0d, required 128", rd_len_o); end
    read_one(7'd0, pat(2, 0));
    read_one(7'd5, pat(2, 5));
    tick();
    release_bank();
  endtask

  task automatic test_concurrent();
    apply_reset();
    write_n(8'd16, 3, 0, 16);
    fork
      write_n(8'd16, 4, 0, 16);
      begin
        for (int a = 0; a < 16; a++) read_one(AW'(a), pat(3, a));
      end
    join
    tick();
    release_bank();
    checks += 2;
    if (rd_bank_valid_o !== 1'b1) begin errors++; $display("FAIL conc_bank1_valid: got %b, required 1", rd_bank_valid_o); end
    if (rd_len_o !== 8'd16) begin errors++; $display("FAIL conc_bank1_len: got %0d, required 16", rd_len_o); end
    for (int a = 15; a >= 0; a--) read_one(AW'(a), pat(4, a));
    tick();
    release_bank();
  endtask

  task automatic test_back_to_back();
    apply_reset();
    write_n(8'd4, 5, 0, 4);
    write_n(8'd4, 6, 0, 4);
    rd_req_i  = 1'b1;
    rd_addr_i = 7'd2;
    rd_done_i = 1'b1;
    sb.push_back(pat(5, 2));
    tick();
    rd_req_i  = 1'b0;
    rd_done_i = 1'b0;
    checks += 2;
    if (full_cnt_o !== 2'd1) begin errors++; $display("FAIL b2b_req_done_cnt: got %0d, required 1", full_cnt_o); end
    if (rd_bank_valid_o !== 1'b1) begin errors++; $display("FAIL b2b_req_done_valid: got %b, required 1", rd_bank_valid_o); end
    read_one(7'd2, pat(6, 2));
    tick();
    release_bank();
    rd_req_i  = 1'b1;
    rd_addr_i = 7'd1;
    tick();
    rd_req_i = 1'b0;
    checks++;
    if (rd_valid_o !== 1'b0) begin errors++; $display("FAIL b2b_ignored_read: got rd_valid_o=%b, required 0", rd_valid_o); end

    // Two consecutive releases drain both banks.
    write_n(8'd3, 7, 0, 3);
    write_n(8'd3, 7, 0, 3);
    rd_done_i = 1'b1;
    tick();
    tick();
    rd_done_i = 1'b0;
    checks++;
    if (full_cnt_o !== 2'd0) begin errors++; $display("FAIL b2b_double_release: got %0d, required 0", full_cnt_o); end

    // Fill completion coinciding with a release of the other bank.
    apply_reset();
    write_n(8'd2, 5, 0, 2);
    write_n(8'd2, 6, 0, 1);
    frame_len_i = 8'd2;
    wr_data_i   = pat(6, 1);
    wr_valid_i  = 1'b1;
    rd_done_i   = 1'b1;
    tick();
    wr_valid_i = 1'b0;
    rd_done_i  = 1'b0;
    checks += 3;
    if (full_cnt_o !== 2'd1) begin errors++; $display("FAIL simul_fill_release_cnt: got %0d, required 1", full_cnt_o); end
    if (rd_bank_valid_o !== 1'b1) begin errors++; $display("FAIL simul_fill_release_valid: got %b, required 1", rd_bank_valid_o); end
    if (rd_len_o !== 8'd2) begin errors++; $display("FAIL simul_fill_release_len: got %0d, required 2", rd_len_o); end
    read_one(7'd1, pat(6, 1));
    tick();
    release_bank();
  endtask

  task automatic test_len_clamp();
    apply_reset();
    write_n(8'd0, 7, 0, 127);
    checks++;
    if (rd_bank_valid_o !== 1'b0) begin errors++; $display("FAIL clamp0_early_full: got %b, required 0", rd_bank_valid_o); end
    write_n(8'd0, 7, 127, 1);
    checks += 2;
    if (rd_bank_valid_o !== 1'b1) begin errors++; $display("FAIL clamp0_full: got %b, required 1", rd_bank_valid_o); end
    if (rd_len_o !== 8'd128) begin errors++; $display("FAIL clamp0_len: got %0d, required 128", rd_len_o); end
    read_one(7'd127, pat(7, 127));
    tick();
    release_bank();
    write_n(8'd200, 1, 0, 127);
    checks++;
    if (rd_bank_valid_o !== 1'b0) begin errors++; $display("FAIL clamp200_early_full: got %b, required 0", rd_bank_valid_o); end
    write_n(8'd200, 1, 127, 1);
    checks += 2;
    if (rd_bank_valid_o !== 1'b1) begin errors++; $display("FAIL clamp200_full: got %b, required 1", rd_bank_valid_o); end
    if (rd_len_o !== 8'd128) begin errors++; $display("FAIL clamp200_len: got %0d, required 128", rd_len_o); end
    read_one(7'd64, pat(1, 64));
    tick();
    release_bank();
  endtask

  task automatic test_zero_pad();
    apply_reset();
    write_n(8'd5, 3, 0, 5);
`ifdef IFMAP_BUF_ZERO_PAD_EN
    read_one(7'd7, 8'h00);
    read_one(7'd4, pat(3, 4));
    read_one(7'd5, 8'h00);
`else
    read_one(7'd4, pat(3, 4));
`endif
    tick();
    release_bank();
  endtask

  task automatic test_reset_mid_fill();
    apply_reset();
    write_n(8'd4, 0, 0, 4);
    write_n(8'd4, 2, 0, 2);
    read_one(7'd1, pat(0, 1));
    tick();
    rst_n = 1'b0;
    #1;
    checks += 6;
    if (wr_ready_o !== 1'b1) begin errors++; $display("FAIL midrst_wr_ready: got %b, required 1", wr_ready_o); end
    if (rd_bank_valid_o !== 1'b0) begin errors++; $display("FAIL midrst_bank_valid: got %b, required 0", rd_bank_valid_o); end
    if (rd_len_o !== '0) begin errors++; $display("FAIL midrst_rd_len: got %0d, required 0", rd_len_o); end
    if (rd_valid_o !== 1'b0) begin errors++; $display("FAIL midrst_rd_valid: got %b, required 0", rd_valid_o); end
    if (rd_data_o !== '0) begin errors++; $display("FAIL midrst_rd_data: got %02h, required 00", rd_data_o); end
    if (full_cnt_o !== 2'd0) begin errors++; $display("FAIL midrst_full_cnt: got %0d, required 0", full_cnt_o); end
    tick();
    rst_n = 1'b1;
    tick();
    write_n(8'd3, 4, 0, 3);
    checks += 2;
    if (rd_bank_valid_o !== 1'b1) begin errors++; $display("FAIL midrst_refill_valid: got %b, required 1", rd_bank_valid_o); end
    if (rd_len_o !== 8'd3) begin errors++; $display("FAIL midrst_refill_len: got %0d, required 3", rd_len_o); end
    read_one(7'd2, pat(4, 2));
    tick();
  endtask

  initial begin
    test_reset();
    test_basic_fill_read();
    test_both_full();
    test_concurrent();
    test_back_to_back();
    test_len_clamp();
    test_zero_pad();
    test_reset_mid_fill();
    tick();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL rd_missing: got %0d outstanding reads, required 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
